tile_renderer: RTL and testbench
================================

# tile_renderer

Registered, parametrised successor to the combinational 2048 tile painter. It sits in the VGA pixel path, one instance per grid cell. It latches the tile exponent only at frame boundaries and converts 2^val to decimal digits with a sequential double-dabble FSM. It paints background, blanked-leading-zero seven-segment digits and a "pop" highlight animation whenever a tile's value increases. RGB is registered with 1-cycle latency, and pixels outside the tile drive black with `tile_hit`=0.

## Interface
- `XIDX`, 0, grid column
- `YIDX`, 0, grid row
- `VAL_W`, 4, exponent width; BIN_W = 2**VAL_W bits of binary value
- `NDIGITS`, 4, displayed decimal digits
- `TILE_LEN`, 117; `LINE_LEN`, 3; `OUTER_PADX`, 214; `OUTER_PADY`, 35
- `LEFT_PAD_D`, 18; `TOP_PAD_D`, 37; `DIGIT_LEN_X`, 18; `DIGIT_LEN_Y`, 42; `PAD_DIGITS`, 3; `SEG_T`, 3 (segment thickness)
- `ANIM_FRAMES`, 8, pop duration in frames
- `clk` in 1, pixel clock
- `rst_n` in 1, asynchronous, active-low reset
- `frame_start` in 1, one-cycle pulse at start of each frame
- `val` in VAL_W, tile exponent; 0 = empty tile
- `counter_x` in 10, horizontal pixel counter
- `counter_y` in 10, vertical pixel counter
- `red_t`, `green_t`, `blue_t` out 8 each, registered colour
- `tile_hit` out 1, registered, pixel lies inside tile
- `busy` out 1, conversion in progress
- `overflow` out 1, current value needs more than NDIGITS digits

## Operation
- Tile origin: xpos = OUTER_PADX + XIDX*(TILE_LEN+LINE_LEN); ypos likewise with OUTER_PADY/YIDX. Inside means xpos ≤ x < xpos+TILE_LEN, and the same test on y.
- Digit k (0 = most significant) occupies x ∈ [xpos+LEFT_PAD_D+k*(DIGIT_LEN_X+PAD_DIGITS), +DIGIT_LEN_X) and y ∈ [ypos+TOP_PAD_D, +DIGIT_LEN_Y).
- `val` is sampled only on `frame_start`. If the sampled value differs from `val_q`, it is stored in `val_q` and the FSM starts.
- FSM states: IDLE → LOAD (bin = 1<<val_q, bcd = 0) → SHIFT (BIN_W cycles of add-3-then-shift on every BCD nibble) → COMMIT (the digit shadow register updates atomically) → IDLE.
- During conversion the previous digits stay displayed. A new differing `val` at `frame_start` while busy is held in `pend` and restarts the FSM from COMMIT; only the latest pending value is kept.
- Leading zeros are blanked, and val_q = 0 blanks all digits. If a nonzero BCD nibble lies above NDIGITS, `overflow`=1 and every digit shows the dash glyph (segment g only).
- Colours:
  - Background comes from the package LUT indexed by val_q (values above the LUT range use the last entry).
  - Digit pixels are dark (0x77,0x6E,0x65) for val_q ≤ 2 and white otherwise.
  - Outside the tile the output is 0,0,0.
- Pop animation: a COMMIT with the new val_q greater than the old val_q and old val_q ≠ 0 loads `anim_cnt` = ANIM_FRAMES. The counter decrements on each `frame_start`. While it is nonzero, the background is the highlight colour (0xFF,0xE0,0x80); digits are unchanged.

## Timing
- Reset: all RGB outputs 0, `tile_hit` 0, `busy` 0, `overflow` 0, val_q 0, digits blank, `anim_cnt` 0, FSM IDLE, `pend` empty.
- Pixel latency: RGB and `tile_hit` for (x,y) appear exactly 1 cycle after the counters present (x,y).
- Conversion: `busy` rises the cycle after the sampling `frame_start`. It stays high for 1 (LOAD) + BIN_W (SHIFT) + 1 (COMMIT) cycles, which is 18 at VAL_W=4. New digits are visible starting the cycle after COMMIT.
- `frame_start` coinciding with COMMIT: the new sample is evaluated against the value being committed.
- Reset asserted mid-conversion: the FSM aborts immediately and all state returns to reset values.

## Structure
- `tile_pkg` holds the FSM state enum, the background colour LUT, digit colours, the highlight colour, and the BLANK (4'hF) and DASH (4'hE) digit codes.
- Sub-module `seg_glyph` is combinational. It takes a digit code, local x/y within the digit box, DIGIT_LEN_X/Y and SEG_T, and returns pixel-on. One instance is shared by computing the active digit index first.

## Test plan
- XIDX=1, YIDX=2, val=11 pulsed with `frame_start` → `busy` is high for 18 cycles, then digits read 2,0,4,8; pixel (360,330) is digit-white one cycle later.
- Same instance, val=1 → only digit 3 shows "2" at x 415..432; pixels at x 352..411 in the digit row show the background colour.
- Pixel (333,300) and (451,300) → black and `tile_hit`=0; (334,275) → `tile_hit`=1.
- val steps 3→4 → `anim_cnt`=8 and the highlight colour is shown for 8 frames, then the LUT colour for 16. Stepping 0→4 triggers no pop.
- VAL_W=4, NDIGITS=4, val=14 (16384) → `overflow`=1 and all four digits are dashes.
- val change during SHIFT, plus `rst_n` pulsed mid-SHIFT in a second run → the pending value converts right after COMMIT; after reset all outputs are 0 and digits are blank.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types, colours and digit codes for the 2048 tile renderer.
package tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_DASH  = 4'hE;

  localparam rgb_t COL_DIGIT_DARK  = 24'h776E65;
  localparam rgb_t COL_DIGIT_WHITE = 24'hFFFFFF;
  localparam rgb_t COL_HIGHLIGHT   = 24'hFFE080;

  // Tile background per exponent; anything past 2048 shares the last entry.
  function automatic rgb_t bg_lut(input int unsigned idx);
    rgb_t c;
    case (idx)
      0:       c = 24'hCDC1B4;
      1:       c = 24'hEEE4DA;
      2:       c = 24'hEDE0C8;
      3:       c = 24'hF2B179;
      4:       c = 24'hF59563;
      5:       c = 24'hF67C5F;
      6:       c = 24'hF65E3B;
      7:       c = 24'hEDCF72;
      8:       c = 24'hEDCC61;
      9:       c = 24'hEDC850;
      10:      c = 24'hEDC53F;
      11:      c = 24'hEDC22E;
      default: c = 24'h3C3A32;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tile_renderer_seg_glyph.sv
// Seven-segment glyph lookup: is local pixel (lx,ly) lit for this digit code.
module seg_glyph
  import tile_pkg::*;
#(
  parameter int unsigned DIGIT_LEN_X = 18,
  parameter int unsigned DIGIT_LEN_Y = 42,
  parameter int unsigned SEG_T       = 3
) (
  input  logic [3:0] code,
  input  logic [9:0] lx,
  input  logic [9:0] ly,
  output logic       pix_on_c
);

  localparam int unsigned HALF = DIGIT_LEN_Y / 2;

  localparam logic [9:0] T_L = 10'(SEG_T);
  localparam logic [9:0] R_L = 10'(DIGIT_LEN_X - SEG_T);
  localparam logic [9:0] B_L = 10'(DIGIT_LEN_Y - SEG_T);
  localparam logic [9:0] H_L = 10'(HALF);
  localparam logic [9:0] G_L = 10'(HALF - SEG_T);

  // Bit order {a,b,c,d,e,f,g}
  logic [6:0] segs_c;
  logic [6:0] hit_c;

  // Segment set for each code
  always_comb begin
    segs_c = 7'b0000000;
    case (code)
      4'd0:      segs_c = 7'b1111110;
      4'd1:      segs_c = 7'b0110000;
      4'd2:      segs_c = 7'b1101101;
      4'd3:      segs_c = 7'b1111001;
      4'd4:      segs_c = 7'b0110011;
      4'd5:      segs_c = 7'b1011011;
      4'd6:      segs_c = 7'b1011111;
      4'd7:      segs_c = 7'b1110000;
      4'd8:      segs_c = 7'b1111111;
      4'd9:      segs_c = 7'b1111011;
      CODE_DASH: segs_c = 7'b0000001;
      default:   segs_c = 7'b0000000;
    endcase
  end

  // Which segment regions cover this pixel; g sits just above the centre line
  always_comb begin
    hit_c    = '0;
    hit_c[6] = (ly < T_L);
    hit_c[5] = (lx >= R_L) && (ly < H_L);
    hit_c[4] = (lx >= R_L) && (ly >= G_L);
    hit_c[3] = (ly >= B_L);
    hit_c[2] = (lx < T_L) && (ly >= G_L);
    hit_c[1] = (lx < T_L) && (ly < H_L);
    hit_c[0] = (ly >= G_L) && (ly < H_L);
  end

  assign pix_on_c = |(segs_c & hit_c);

endmodule

// File: rtl/tile_renderer.sv
// One 2048 grid cell: frame-latched exponent, sequential binary-to-BCD, registered pixel colour.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int unsigned XIDX        = 0,
  parameter int unsigned YIDX        = 0,
  parameter int unsigned VAL_W       = 4,
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned TILE_LEN    = 117,
  parameter int unsigned LINE_LEN    = 3,
  parameter int unsigned OUTER_PADX  = 214,
  parameter int unsigned OUTER_PADY  = 35,
  parameter int unsigned LEFT_PAD_D  = 18,
  parameter int unsigned TOP_PAD_D   = 37,
  parameter int unsigned DIGIT_LEN_X = 18,
  parameter int unsigned DIGIT_LEN_Y = 42,
  parameter int unsigned PAD_DIGITS  = 3,
  parameter int unsigned SEG_T       = 3,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [VAL_W-1:0] val,
  input  logic [9:0]       counter_x,
  input  logic [9:0]       counter_y,
  output logic [7:0]       red_t,
  output logic [7:0]       green_t,
  output logic [7:0]       blue_t,
  output logic             tile_hit,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned BIN_W     = 2 ** VAL_W;
  localparam int unsigned BCD_GUESS = (BIN_W * 301) / 1000 + 1;
  localparam int unsigned BCD_N     = (BCD_GUESS > NDIGITS) ? BCD_GUESS : NDIGITS;
  localparam int unsigned CNT_W     = $clog2(BIN_W);
  localparam int unsigned ANIM_W    = $clog2(ANIM_FRAMES + 1);
  localparam int unsigned SEL_W     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned CW        = 12;

  localparam int unsigned XPOS  = OUTER_PADX + XIDX * (TILE_LEN + LINE_LEN);
  localparam int unsigned YPOS  = OUTER_PADY + YIDX * (TILE_LEN + LINE_LEN);
  localparam int unsigned DX0   = XPOS + LEFT_PAD_D;
  localparam int unsigned PITCH = DIGIT_LEN_X + PAD_DIGITS;

  localparam logic [CW-1:0] X_LO  = CW'(XPOS);
  localparam logic [CW-1:0] X_HI  = CW'(XPOS + TILE_LEN);
  localparam logic [CW-1:0] Y_LO  = CW'(YPOS);
  localparam logic [CW-1:0] Y_HI  = CW'(YPOS + TILE_LEN);
  localparam logic [CW-1:0] DY_LO = CW'(YPOS + TOP_PAD_D);
  localparam logic [CW-1:0] DY_HI = CW'(YPOS + TOP_PAD_D + DIGIT_LEN_Y);

  conv_state_e state_q, state_nx;

  logic [VAL_W-1:0]         val_q, pend_val, disp_val, new_val_c;
  logic                     pend_valid, load_val_c, fs_diff_c, pop_c;
  logic [BIN_W-1:0]         bin_q;
  logic [4*BCD_N-1:0]       bcd_q, bcd_adj_c;
  logic [CNT_W-1:0]         cnt_q;
  logic [NDIGITS-1:0][3:0]  digits_q, digits_nx_c;
  logic                     ovf_nx_c, lead_c;
  logic [3:0]               nib_c;
  logic [ANIM_W-1:0]        anim_q;

  logic [CW-1:0]            x_c, y_c;
  logic                     in_tile_c, in_row_c, dig_hit_c, glyph_on_c;
  logic [SEL_W-1:0]         dig_sel_c;
  logic [9:0]               lx_c, ly_c;
  logic [3:0]               code_c;
  rgb_t                     bg_c, fg_c, pix_c;

  assign fs_diff_c = frame_start && (val != val_q);

  // Conversion FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next state; a pending or freshly sampled value chains straight from COMMIT into LOAD
  always_comb begin
    state_nx   = state_q;
    load_val_c = 1'b0;
    new_val_c  = val;
    case (state_q)
      ST_IDLE: begin
        if (fs_diff_c) begin
          state_nx   = ST_LOAD;
          load_val_c = 1'b1;
        end
      end
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(BIN_W - 1)) state_nx = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nx = ST_IDLE;
        if (fs_diff_c) begin
          state_nx   = ST_LOAD;
          load_val_c = 1'b1;
        end else if (!frame_start && pend_valid) begin
          state_nx   = ST_LOAD;
          load_val_c = 1'b1;
          new_val_c  = pend_val;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Latched exponent and the single-entry pending slot (latest sample wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q      <= '0;
      pend_val   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load_val_c) val_q <= new_val_c;
      if ((state_q == ST_LOAD || state_q == ST_SHIFT) && frame_start) begin
        pend_valid <= fs_diff_c;
        pend_val   <= val;
      end else if (state_q == ST_COMMIT) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Add-3 correction on every BCD nibble before each shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_N); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Double-dabble datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_LOAD) begin
      bin_q <= BIN_W'(1) << val_q;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      {bcd_q, bin_q} <= {bcd_adj_c, bin_q} << 1;
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  // Digit codes to commit: leading-zero blanking, overflow dashes, empty tile blank
  always_comb begin
    ovf_nx_c    = 1'b0;
    lead_c      = 1'b1;
    nib_c       = 4'd0;
    digits_nx_c = '0;
    for (int i = int'(BCD_N) - 1; i >= int'(NDIGITS); i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf_nx_c = 1'b1;
    end
    for (int k = 0; k < int'(NDIGITS); k++) begin
      nib_c = bcd_q[4*(int'(NDIGITS) - 1 - k) +: 4];
      if (nib_c != 4'd0 || k == int'(NDIGITS) - 1) lead_c = 1'b0;
      digits_nx_c[k] = lead_c ? CODE_BLANK : nib_c;
    end
    if (val_q == '0) begin
      ovf_nx_c    = 1'b0;
      digits_nx_c = {NDIGITS{CODE_BLANK}};
    end else if (ovf_nx_c) begin
      digits_nx_c = {NDIGITS{CODE_DASH}};
    end
  end

  assign pop_c = (state_q == ST_COMMIT) && (val_q > disp_val) && (disp_val != '0);

  // Shadow digits switch atomically at COMMIT so the old value stays on screen meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= {NDIGITS{CODE_BLANK}};
      overflow <= 1'b0;
      disp_val <= '0;
    end else if (state_q == ST_COMMIT) begin
      digits_q <= digits_nx_c;
      overflow <= ovf_nx_c;
      disp_val <= val_q;
    end
  end

  // Pop animation frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           anim_q <= '0;
    else if (pop_c)                       anim_q <= ANIM_W'(ANIM_FRAMES);
    else if (frame_start && anim_q != '0) anim_q <= anim_q - ANIM_W'(1);
  end

  // Busy tracks the FSM leaving IDLE, aligned with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= (state_nx != ST_IDLE);
  end

  assign x_c       = {2'b00, counter_x};
  assign y_c       = {2'b00, counter_y};
  assign in_tile_c = (x_c >= X_LO) && (x_c < X_HI) && (y_c >= Y_LO) && (y_c < Y_HI);
  assign in_row_c  = (y_c >= DY_LO) && (y_c < DY_HI);
  assign ly_c      = 10'(y_c - DY_LO);

  // Pick the digit box under the pixel so one glyph decoder serves all digits
  always_comb begin
    dig_hit_c = 1'b0;
    dig_sel_c = '0;
    lx_c      = '0;
    for (int k = 0; k < int'(NDIGITS); k++) begin
      if (x_c >= CW'(DX0 + k * PITCH) && x_c < CW'(DX0 + k * PITCH + DIGIT_LEN_X)) begin
        dig_hit_c = in_row_c;
        dig_sel_c = SEL_W'(k);
        lx_c      = 10'(x_c - CW'(DX0 + k * PITCH));
      end
    end
  end

  assign code_c = digits_q[dig_sel_c];

  seg_glyph #(
    .DIGIT_LEN_X (DIGIT_LEN_X),
    .DIGIT_LEN_Y (DIGIT_LEN_Y),
    .SEG_T       (SEG_T)
  ) u_glyph (
    .code     (code_c),
    .lx       (lx_c),
    .ly       (ly_c),
    .pix_on_c (glyph_on_c)
  );

  // Pixel colour selection
  always_comb begin
    bg_c  = (anim_q != '0) ? COL_HIGHLIGHT : bg_lut(32'(val_q));
    fg_c  = (32'(val_q) <= 32'd2) ? COL_DIGIT_DARK : COL_DIGIT_WHITE;
    pix_c = '0;
    if (in_tile_c) pix_c = (dig_hit_c && glyph_on_c) ? fg_c : bg_c;
  end

  // One-cycle registered pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_t    <= '0;
      green_t  <= '0;
      blue_t   <= '0;
      tile_hit <= 1'b0;
    end else begin
      red_t    <= pix_c.r;
      green_t  <= pix_c.g;
      blue_t   <= pix_c.b;
      tile_hit <= in_tile_c;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer at grid cell (1,2).
module tb_tile_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] val = 4'd0;
  logic [9:0] counter_x = 10'd0;
  logic [9:0] counter_y = 10'd0;
  logic [7:0] red_t, green_t, blue_t;
  logic       tile_hit, busy, overflow;
  logic [23:0] rgb;

  int checks = 0;
  int failures = 0;

  assign rgb = {red_t, green_t, blue_t};

  tile_renderer #(.XIDX(1), .YIDX(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .val         (val),
    .counter_x   (counter_x),
    .counter_y   (counter_y),
    .red_t       (red_t),
    .green_t     (green_t),
    .blue_t      (blue_t),
    .tile_hit    (tile_hit),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic show(input int unsigned x, input int unsigned y);
    counter_x = 10'(x);
    counter_y = 10'(y);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] v);
    val = v;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    counter_x = 10'd360;
    counter_y = 10'd330;
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=%h", rgb, 24'h0); end
    checks++; if (tile_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", tile_hit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tile_hit !== 1'b1) begin failures++; $display("FAIL reset_after_hit got=%b exp=1", tile_hit); end
    checks++; if (rgb !== 24'hCDC1B4) begin failures++; $display("FAIL reset_after_bg got=%h exp=%h", rgb, 24'hCDC1B4); end
  endtask

  task automatic test_convert_2048();
    int unsigned xs[6] = '{360, 381, 381, 402, 402, 423};
    int unsigned ys[6] = '{330, 313, 330, 313, 330, 313};
    logic [23:0] ex[6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hEDC22E, 24'hEDC22E, 24'hFFFFFF, 24'hFFFFFF};
    int cnt = 0;
    pulse(4'd11);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 18) begin failures++; $display("FAIL conv_busy_len got=%0d exp=18", cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL conv_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 6; i++) begin
      show(xs[i], ys[i]);
      checks++;
      if (rgb !== ex[i]) begin
        failures++; $display("FAIL conv_px(%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_small_value();
    int unsigned xs[5] = '{420, 360, 381, 402, 360};
    int unsigned ys[5] = '{313, 313, 313, 313, 330};
    logic [23:0] ex[5] = '{24'h776E65, 24'hEEE4DA, 24'hEEE4DA, 24'hEEE4DA, 24'hEEE4DA};
    pulse(4'd1);
    repeat (25) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      show(xs[i], ys[i]);
      checks++;
      if (rgb !== ex[i]) begin
        failures++; $display("FAIL small_px(%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_bounds();
    int unsigned xs[5] = '{333, 451, 334, 450, 334};
    int unsigned ys[5] = '{300, 300, 275, 391, 392};
    logic hx[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [23:0] ex[5] = '{24'h0, 24'h0, 24'hEEE4DA, 24'hEEE4DA, 24'h0};
    for (int i = 0; i < 5; i++) begin
      show(xs[i], ys[i]);
      checks++;
      if (tile_hit !== hx[i] || rgb !== ex[i]) begin
        failures++;
        $display("FAIL bound_px(%0d,%0d) got=%b/%h exp=%b/%h", xs[i], ys[i], tile_hit, rgb, hx[i], ex[i]);
      end
    end
    counter_x = 10'd334; counter_y = 10'd275;
    @(negedge clk);
    counter_x = 10'd333;
    checks++; if (tile_hit !== 1'b1) begin failures++; $display("FAIL latency_hold got=%b exp=1", tile_hit); end
    @(negedge clk);
    checks++; if (tile_hit !== 1'b0) begin failures++; $display("FAIL latency_next got=%b exp=0", tile_hit); end
  endtask

  task automatic test_pop();
    counter_x = 10'd340; counter_y = 10'd280;
    pulse(4'd3);
    repeat (25) @(negedge clk);
    checks++; if (rgb !== 24'hFFE080) begin failures++; $display("FAIL pop_1to3 got=%h exp=%h", rgb, 24'hFFE080); end
    repeat (8) pulse(4'd3);
    @(negedge clk);
    checks++; if (rgb !== 24'hF2B179) begin failures++; $display("FAIL pop_drain3 got=%h exp=%h", rgb, 24'hF2B179); end
    pulse(4'd4);
    repeat (25) @(negedge clk);
    checks++; if (rgb !== 24'hFFE080) begin failures++; $display("FAIL pop_3to4 got=%h exp=%h", rgb, 24'hFFE080); end
    for (int i = 1; i <= 7; i++) begin
      pulse(4'd4);
      @(negedge clk);
      checks++;
      if (rgb !== 24'hFFE080) begin failures++; $display("FAIL pop_frame%0d got=%h exp=%h", i, rgb, 24'hFFE080); end
    end
    pulse(4'd4);
    @(negedge clk);
    checks++; if (rgb !== 24'hF59563) begin failures++; $display("FAIL pop_end got=%h exp=%h", rgb, 24'hF59563); end
    pulse(4'd0);
    repeat (25) @(negedge clk);
    show(423, 313);
    checks++; if (rgb !== 24'hCDC1B4) begin failures++; $display("FAIL empty_blank got=%h exp=%h", rgb, 24'hCDC1B4); end
    pulse(4'd4);
    repeat (25) @(negedge clk);
    show(340, 280);
    checks++; if (rgb !== 24'hF59563) begin failures++; $display("FAIL nopop_0to4 got=%h exp=%h", rgb, 24'hF59563); end
  endtask

  task automatic test_overflow();
    int unsigned xs[4] = '{360, 360, 423, 423};
    int unsigned ys[4] = '{330, 313, 330, 313};
    logic [23:0] ex[4] = '{24'hFFFFFF, 24'hFFE080, 24'hFFFFFF, 24'hFFE080};
    pulse(4'd14);
    repeat (25) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      show(xs[i], ys[i]);
      checks++;
      if (rgb !== ex[i]) begin
        failures++; $display("FAIL ovf_px(%0d,%0d) got=%h exp=%h", xs[i], ys[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_pending();
    int unsigned xs[3] = '{402, 423, 360};
    logic [23:0] ex[3] = '{24'hFFFFFF, 24'hFFE080, 24'hFFE080};
    int cnt = 0;
    pulse(4'd5);
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1) cnt++;
      if (i == 5) begin val = 4'd6; frame_start = 1'b1; end
      else frame_start = 1'b0;
      @(negedge clk);
    end
    frame_start = 1'b0;
    checks++; if (cnt != 36) begin failures++; $display("FAIL pend_busy_len got=%0d exp=36", cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pend_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 3; i++) begin
      show(xs[i], 313);
      checks++;
      if (rgb !== ex[i]) begin
        failures++; $display("FAIL pend_px(%0d,313) got=%h exp=%h", xs[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    counter_x = 10'd360; counter_y = 10'd330;
    pulse(4'd9);
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (rgb !== 24'h0 || tile_hit !== 1'b0) begin failures++; $display("FAIL mid_px got=%h/%b exp=0/0", rgb, tile_hit); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rgb !== 24'hCDC1B4 || tile_hit !== 1'b1) begin failures++; $display("FAIL mid_after_px got=%h/%b exp=%h/1", rgb, tile_hit, 24'hCDC1B4); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_after_ovf got=%b exp=0", overflow); end
    show(423, 313);
    checks++; if (rgb !== 24'hCDC1B4) begin failures++; $display("FAIL mid_blank got=%h exp=%h", rgb, 24'hCDC1B4); end
    repeat (25) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_convert_2048();
    test_small_value();
    test_bounds();
    test_pop();
    test_overflow();
    test_pending();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
